// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Two-flop synchronizer plus stability-checking FSM that turns a
//            bouncing push-button into a clean level and press/release strobes.
// Revision : 1.0
// ============================================================================
module button_debouncer #(
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_raw,
    output logic        btn_level,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic [15:0] press_count
);

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [15:0]      r_press_count;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_done;
    logic             w_press_acc;
    logic             w_release_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_acc   = 1'b0;
        w_release_acc = 1'b0;
        w_cnt_done    = (r_cnt == c_CNT_LAST);
        case (r_state)
            RELEASED: begin
                if (r_sync2) begin
                    w_state_nxt = PRESS_CHECK;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_CHECK: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_press_acc = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASE_CHECK;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_CHECK: begin
                if (r_sync2) begin
                    w_state_nxt   = PRESSED;
                    w_cnt_nxt     = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt   = RELEASED;
                    w_cnt_nxt     = '0;
                    w_release_acc = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Level is registered from the next state so it flips on the same edge as the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RELEASED;
            r_cnt         <= '0;
            r_level       <= 1'b0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_press_count <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_level       <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_CHECK);
            r_press       <= w_press_acc;
            r_release     <= w_release_acc;
            r_press_count <= r_press_count + 16'(w_press_acc);
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign press_count   = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Scoreboard bench for button_debouncer with STABLE_CYCLES of 4 and 1.
// Revision : 1.0
// ============================================================================
module tb_button_debouncer;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        btn4  = 1'b0;
    logic        btn1  = 1'b0;
    logic        lvl4, pp4, rp4;
    logic        lvl1, pp1, rp1;
    logic [15:0] cnt4, cnt1;

    typedef struct {
        bit kind;
        int at;
        int cnt;
    } ev_t;

    ev_t         q [2][$];
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp4    = 16'h0000;
    logic [15:0] exp1    = 16'h0000;

    button_debouncer #(.STABLE_CYCLES(4), .CNT_W(3)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn4),
        .btn_level     (lvl4),
        .press_pulse   (pp4),
        .release_pulse (rp4),
        .press_count   (cnt4)
    );

    button_debouncer #(.STABLE_CYCLES(1), .CNT_W(20)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn1),
        .btn_level     (lvl1),
        .press_pulse   (pp1),
        .release_pulse (rp1),
        .press_count   (cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input bit kind, input int at, input int cnt);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.cnt  = cnt;
        q[i].push_back(e);
    endtask

    task automatic mon(input int i, input logic pp, input logic rp,
                       input logic lvl, input logic [15:0] cnt);
        ev_t e;
        if (pp || rp) begin
            check($sformatf("excl%0d", i), int'(pp & rp), 0);
            if (q[i].size() == 0) begin
                check($sformatf("spurious%0d", i), int'({pp, rp}), 0);
            end else begin
                e = q[i].pop_front();
                check($sformatf("kind%0d", i), int'(pp), int'(e.kind));
                check($sformatf("when%0d", i), cyc, e.at);
                check($sformatf("lvl%0d", i), int'(lvl), int'(e.kind));
                check($sformatf("count%0d", i), int'(cnt), e.cnt);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, pp4, rp4, lvl4, cnt4);
        mon(1, pp1, rp1, lvl1, cnt1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] bounce;
        bounce = 4'b0101;

        tick(2);
        check("rst_lvl4", int'(lvl4), 0);
        check("rst_pp4",  int'(pp4),  0);
        check("rst_rp4",  int'(rp4),  0);
        check("rst_cnt4", int'(cnt4), 0);
        check("rst_lvl1", int'(lvl1), 0);
        check("rst_cnt1", int'(cnt1), 0);
        reset = 1'b0;
        tick(3);

        // Clean press then release, pulse STABLE_CYCLES+2 edges after first sampling edge.
        btn4 = 1'b1;
        exp4 = exp4 + 16'd1;
        push(0, 1'b1, cyc + 1 + 6, int'(exp4));
        tick(14);
        check("hold_lvl4", int'(lvl4), 1);
        btn4 = 1'b0;
        push(0, 1'b0, cyc + 1 + 6, int'(exp4));
        tick(14);
        check("idle_lvl4", int'(lvl4), 0);

        // Bounce: 1,0,1,0 single cycles, then settle high.
        for (int k = 0; k < 4; k++) begin
            btn4 = bounce[k];
            tick(1);
        end
        btn4 = 1'b1;
        exp4 = exp4 + 16'd1;
        push(0, 1'b1, cyc + 1 + 6, int'(exp4));
        tick(14);

        // Release glitch of 3 cycles must not release.
        btn4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("glitch_lvl4", int'(lvl4), 1);
        end
        btn4 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("glitch_lvl4", int'(lvl4), 1);
        end
        btn4 = 1'b0;
        push(0, 1'b0, cyc + 1 + 6, int'(exp4));
        tick(14);

        // Reset in the middle of a press check, button still held afterwards.
        btn4 = 1'b1;
        tick(4);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_lvl4", int'(lvl4), 0);
        check("mid_rst_pp4",  int'(pp4),  0);
        check("mid_rst_rp4",  int'(rp4),  0);
        check("mid_rst_cnt4", int'(cnt4), 0);
        check("mid_rst_cnt1", int'(cnt1), 0);
        exp4 = 16'h0000;
        exp1 = 16'h0000;
        tick(1);
        reset = 1'b0;
        exp4 = exp4 + 16'd1;
        push(0, 1'b1, cyc + 1 + 6, int'(exp4));
        tick(14);
        check("post_rst_lvl4", int'(lvl4), 1);

        // Minimum window: STABLE_CYCLES=1 gives a 3-edge latency.
        btn1 = 1'b1;
        exp1 = exp1 + 16'd1;
        push(1, 1'b1, cyc + 1 + 3, int'(exp1));
        tick(8);
        btn1 = 1'b0;
        push(1, 1'b0, cyc + 1 + 3, int'(exp1));
        tick(8);

        // Count wrap: preload near the top, then real presses across 0xFFFF -> 0x0000.
        force dut1.r_press_count = 16'hFFFD;
        tick(1);
        release dut1.r_press_count;
        exp1 = 16'hFFFD;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            btn1 = 1'b1;
            exp1 = exp1 + 16'd1;
            push(1, 1'b1, cyc + 1 + 3, int'(exp1));
            tick(5);
            btn1 = 1'b0;
            push(1, 1'b0, cyc + 1 + 3, int'(exp1));
            tick(5);
        end
        check("wrap_cnt1", int'(cnt1), 1);

        tick(10);
        check("pending4", q[0].size(), 0);
        check("pending1", q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
# button_debouncer

Cleans the raw, bouncing flap push-button of the Flappy Bird game into a stable level plus single-cycle press and release events for the game-control logic. It consumes the same `clk`/`reset` domain as the rest of the design. It replaces ad-hoc free-running counter sampling with a per-button stability-checking state machine. One instance is placed per physical button, between the board pin and the bird-physics / game-state logic.

## Interface
- `STABLE_CYCLES`, default 500000, is the number of consecutive cycles the synchronized input must hold a new value before it is accepted (10 ms at 50 MHz). Legal range is 1 to 2^CNT_W.
- `CNT_W`, default 20, is the width of the stability counter.
- `clk`, input, width 1: system clock. All logic is on the rising edge.
- `reset`, input, width 1: asynchronous, active-high reset, per the decided interface.
- `btn_raw`, input, width 1: raw button pin, asynchronous to `clk`, high = pressed.
- `btn_level`, output, width 1: debounced button state, high = pressed.
- `press_pulse`, output, width 1: one-cycle strobe on an accepted press.
- `release_pulse`, output, width 1: one-cycle strobe on an accepted release.
- `press_count`, output, width 16: number of accepted presses, wraps modulo 2^16.

## Operation
- **Synchronizer.** Two flops, `sync1` then `sync2`, both reset to 0. The FSM sees only `sync2`.
- **States.** RELEASED (reset state), PRESS_CHECK, PRESSED, RELEASE_CHECK. The state is held in a register.
- **Stability counter.** `cnt`, CNT_W bits, resets to 0.
- **RELEASED:**
  - `sync2`=1: go to PRESS_CHECK with `cnt`<=0.
  - Otherwise stay.
- **PRESS_CHECK:**
  - `sync2`=0: go to RELEASED with `cnt`<=0. This is a rejected bounce and produces no pulse.
  - `sync2`=1 and `cnt`==STABLE_CYCLES-1: go to PRESSED, assert `press_pulse` for one cycle, and `press_count`<=`press_count`+1.
  - Otherwise `cnt`<=`cnt`+1.
- **PRESSED:**
  - `sync2`=0: go to RELEASE_CHECK with `cnt`<=0.
  - Otherwise stay.
- **RELEASE_CHECK:** mirror of PRESS_CHECK.
  - `sync2`=1: return to PRESSED with no pulse.
  - `sync2`=0 and `cnt`==STABLE_CYCLES-1: go to RELEASED and assert `release_pulse` for one cycle.
  - Otherwise increment `cnt`.
- **`btn_level`** is high exactly in PRESSED and RELEASE_CHECK. It changes in the same cycle the corresponding pulse is high.
- **Registered outputs.** All outputs come straight from flops, with no combinational path from `btn_raw`.
- **Counter limits.** `cnt` never exceeds STABLE_CYCLES-1, so it never wraps. `press_count` wraps from 0xFFFF to 0x0000.
- **Exclusivity.** `press_pulse` and `release_pulse` are never high in the same cycle. Two consecutive press pulses are separated by at least 2·STABLE_CYCLES+2 cycles.

## Timing
- **Reset values.** While `reset` is asserted:
  - `btn_level`=0, `press_pulse`=0, `release_pulse`=0.
  - `press_count`=0, `cnt`=0, state=RELEASED.
  - `sync1`=`sync2`=0.
- **Reset timing.** Assertion takes effect immediately, without waiting for a clock edge. Deassertion is assumed synchronized externally.
- **Reset mid-operation.** Reset in any state discards the in-progress check. If the button is still held after reset deasserts, the bench must observe a fresh, full-latency press.
- **Press latency.** Let `btn_raw` be stable high before clock edge E0.
  - `sync2`=1 after E0+1.
  - The FSM enters PRESS_CHECK at E0+2.
  - The FSM enters PRESSED at E0+2+STABLE_CYCLES.
  - `press_pulse` and the rising `btn_level` are therefore visible STABLE_CYCLES+2 edges after E0.
  - Release latency is identical.
- **Bounce rule.** A single-cycle opposite value on `sync2` during a check restarts the full STABLE_CYCLES window.
- **`STABLE_CYCLES`=1 case.** A check completes on the edge after entry.

## Test plan
1. **Reset.** Assert `reset` mid-PRESS_CHECK with `btn_raw`=1 and STABLE_CYCLES=4. Required: all outputs 0 immediately. After deassert, `press_pulse` occurs 6 edges after the first sampling edge and `press_count`=1.
2. **Clean press and release.** STABLE_CYCLES=4. `btn_raw` rises before edge 0. Required: `press_pulse`=1 for exactly one cycle after edge 6, and `btn_level`=1 from then on. Dropping `btn_raw` before edge 20 gives `release_pulse` after edge 26 and `btn_level`=0.
3. **Bounce rejection.** STABLE_CYCLES=4. Toggle `btn_raw` 1,0,1,0,1 with a 2-cycle period, then hold 1. Required: exactly one `press_pulse`, 6 edges after the final rising sample, and `press_count`=1.
4. **Release glitch.** While PRESSED, pulse `btn_raw` low for 3 cycles with STABLE_CYCLES=4. Required: no `release_pulse`, and `btn_level` stays 1.
5. **Count wrap.** Force 65536 accepted presses using STABLE_CYCLES=1. Required: `press_count` reads 0xFFFF then 0x0000. Also check `press_pulse` and `release_pulse` are never simultaneously 1.
6. **Minimum window.** STABLE_CYCLES=1 with a clean press. Required: `press_pulse` after edge 3 counted from E0.
